// File: rtl/serial_bus_pkg.sv
// rtl/serial_bus_pkg.sv - shared types and constants for the serial bus ports
// Purpose: receiver FSM state type and frame geometry shared by master_in_port
//          and slave_out_port.
// Ports:   none (package).
package serial_bus_pkg;

  localparam int SB_DATA_WIDTH   = 8;
  localparam int SB_DONE_TIMEOUT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HSHK  = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } rx_state_t;

endpackage

// File: rtl/serial_shift_in.sv
// rtl/serial_shift_in.sv - LSB-first serial-to-parallel shift register with bit counter
// Purpose: captures one serial bit per shift_en cycle into data[bit_cnt] and
//          flags the final bit of the frame.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      restart the bit counter at bit 0 (start of frame)
//   shift_en   capture din this cycle and advance the counter
//   din        serial input bit
//   data       assembled word
//   last_bit   counter is on the final bit of the frame
module serial_shift_in #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last_bit
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (clear) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d[bit_cnt_q] = din;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign data     = shift_q;
  assign last_bit = (bit_cnt_q == CNT_LAST);

endmodule

// File: rtl/master_in_port.sv
// rtl/master_in_port.sv - master-side serial frame receiver with 1-entry output buffer
// Purpose: handshakes with the slave (s_valid / m_ready), shifts in DATA_WIDTH
//          bits LSB first, validates the s_tx_done end-of-frame strobe and
//          hands good words to the core through a valid/ready buffer.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   s_valid     slave has a frame to send
//   rx_data     serial data from slave, LSB first
//   s_tx_done   slave end-of-frame strobe
//   m_ready     master ready, held for the whole frame
//   out_data    received word
//   out_valid   out_data holds an unconsumed word
//   out_ready   core accepts out_data
//   frame_err   1-cycle pulse when a frame is discarded
module master_in_port
  import serial_bus_pkg::*;
#(
  parameter int DATA_WIDTH   = SB_DATA_WIDTH,
  parameter int DONE_TIMEOUT = SB_DONE_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic                  rx_data,
  input  logic                  s_tx_done,
  output logic                  m_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(DONE_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);

  rx_state_t             state_q, state_d;
  logic                  m_ready_q, m_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  frame_err_q, frame_err_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                  cnt_clear;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] shift_data;
  logic                  last_bit;

  serial_shift_in #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .shift_en (shift_en),
    .din      (rx_data),
    .data     (shift_data),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    m_ready_d   = m_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;
    timer_d     = timer_q;
    cnt_clear   = 1'b0;
    shift_en    = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        m_ready_d = 1'b0;
        // Only accept a new frame if its word will have somewhere to land.
        if (s_valid && (!out_valid_q || out_ready)) begin
          state_d   = HSHK;
          m_ready_d = 1'b1;
        end
      end
      HSHK: begin
        if (s_valid) begin
          state_d   = SHIFT;
          cnt_clear = 1'b1;
        end else begin
          state_d   = IDLE;
          m_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        // Slave abandoning the frame or ending it early both invalidate the word.
        if (!s_valid || s_tx_done) begin
          state_d     = IDLE;
          m_ready_d   = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_d = CHECK;
            timer_d = '0;
          end
        end
      end
      CHECK: begin
        if (s_tx_done) begin
          state_d     = IDLE;
          m_ready_d   = 1'b0;
          out_data_d  = shift_data;
          out_valid_d = 1'b1;
          timer_d     = '0;
        end else if (timer_q == TIMER_LAST) begin
          // DONE_TIMEOUT cycles spent in CHECK without the strobe.
          state_d     = IDLE;
          m_ready_d   = 1'b0;
          frame_err_d = 1'b1;
          timer_d     = '0;
        end else if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        m_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      m_ready_q   <= m_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      timer_q     <= timer_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_master_in_port.sv
// tb/tb_master_in_port.sv - directed table-driven bench for master_in_port
module tb_master_in_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       rx_data = 1'b0;
  logic       s_tx_done = 1'b0;
  logic       m_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  master_in_port dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .rx_data   (rx_data),
    .s_tx_done (s_tx_done),
    .m_ready   (m_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // mode: 0 good frame, 1 s_valid drop at bit k, 2 no s_tx_done, 3 s_tx_done at bit k
  typedef struct {
    logic [7:0] data;
    int         mode;
    int         k;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_m_ready(output int waited);
    waited = 0;
    while (!m_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("m_ready_timeout", {31'd0, m_ready}, 32'd1);
  endtask

  // Leaves s_valid at 1 after a good or timed-out frame; caller decides when to drop it.
  task automatic send_frame(input logic [7:0] data, input int mode, input int k, output int waited);
    bit aborted;
    aborted = 1'b0;
    s_valid = 1'b1;
    wait_m_ready(waited);
    tick();  // handshake edge T
    for (int i = 0; i < 8 && !aborted; i++) begin
      if (mode == 1 && i == k) begin
        s_valid = 1'b0;
        tick();
        chk("drop_err", {31'd0, frame_err}, 32'd1);
        chk("drop_mready", {31'd0, m_ready}, 32'd0);
        chk("drop_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("drop_err_pulse", {31'd0, frame_err}, 32'd0);
        aborted = 1'b1;
      end else if (mode == 3 && i == k) begin
        s_tx_done = 1'b1;
        tick();
        s_tx_done = 1'b0;
        s_valid = 1'b0;
        chk("early_err", {31'd0, frame_err}, 32'd1);
        chk("early_mready", {31'd0, m_ready}, 32'd0);
        chk("early_valid", {31'd0, out_valid}, 32'd0);
        aborted = 1'b1;
      end else begin
        rx_data = data[i];
        tick();
      end
    end
    if (!aborted) begin
      if (mode == 2) begin
        for (int c = 1; c <= 4; c++) begin
          tick();
          chk($sformatf("timeout_err_c%0d", c), {31'd0, frame_err}, (c == 4) ? 32'd1 : 32'd0);
        end
        chk("timeout_valid", {31'd0, out_valid}, 32'd0);
        chk("timeout_mready", {31'd0, m_ready}, 32'd0);
      end else begin
        s_tx_done = 1'b1;
        tick();  // T+9
        s_tx_done = 1'b0;
        chk("good_valid", {31'd0, out_valid}, 32'd1);
        chk("good_data", {24'd0, out_data}, {24'd0, data});
        chk("good_mready", {31'd0, m_ready}, 32'd0);
        chk("good_err", {31'd0, frame_err}, 32'd0);
      end
    end
  endtask

  initial begin
    int w;

    vecs[0] = '{data: 8'hCC, mode: 0, k: 0, exp_valid: 1'b1, exp_data: 8'hCC};
    vecs[1] = '{data: 8'h5A, mode: 0, k: 0, exp_valid: 1'b1, exp_data: 8'h5A};
    vecs[2] = '{data: 8'hCC, mode: 1, k: 4, exp_valid: 1'b0, exp_data: 8'h5A};
    vecs[3] = '{data: 8'h3C, mode: 2, k: 0, exp_valid: 1'b0, exp_data: 8'h5A};
    vecs[4] = '{data: 8'h96, mode: 3, k: 3, exp_valid: 1'b0, exp_data: 8'h5A};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_mready", {31'd0, m_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Table of single frames, out_ready held high.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].mode, vecs[v].k, w);
      chk($sformatf("v%0d_hshk_wait", v), w, 32'd1);
      s_valid = 1'b0;
      tick();
      // Good words are consumed on the first visible cycle (T+10).
      chk($sformatf("v%0d_valid_after", v), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_data_after", v), {24'd0, out_data}, {24'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_err_after", v), {31'd0, frame_err}, 32'd0);
      tick();
    end

    // Backpressure: word A5 held while out_ready=0, no new handshake.
    out_ready = 1'b0;
    send_frame(8'hA5, 0, 0, w);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("bp_data_hold", {24'd0, out_data}, 32'hA5);
      chk("bp_mready_low", {31'd0, m_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_drain_hshk", {31'd0, m_ready}, 32'd1);
    // Slave withdraws during handshake: clean return to IDLE.
    s_valid = 1'b0;
    tick();
    chk("hshk_abort_mready", {31'd0, m_ready}, 32'd0);
    chk("hshk_abort_err", {31'd0, frame_err}, 32'd0);
    tick();

    // Reset at bit 5 of a frame.
    s_valid = 1'b1;
    wait_m_ready(w);
    tick();
    for (int i = 0; i < 5; i++) begin
      rx_data = i[0];
      tick();
    end
    rst = 1'b1;
    tick();
    chk("midrst_mready", {31'd0, m_ready}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'd0);
    chk("midrst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back frames 01 then FF, s_valid held high throughout.
    send_frame(8'h01, 0, 0, w);
    send_frame(8'hFF, 0, 0, w);
    chk("b2b_idle_gap", w, 32'd1);
    s_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);
    chk("b2b_last_data", {24'd0, out_data}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
